// File: rtl/matrix_pkg.sv
// Shared definitions for the 3x3 matrix blocks: element geometry, the
// sequencer state type and the flattened-bus offset helper.
package matrix_pkg;

    localparam int MAT_N  = 3;
    localparam int ELEM_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BLANK,
        WAIT
    } state_t;

    // Bit offset of element (row, col) inside a row-major flattened matrix bus.
    function automatic int elem_off(input int row, input int col);
        return ELEM_W * (MAT_N * row + col);
    endfunction

endpackage

// File: rtl/ijk_counter.sv
// Nested (i, j, k) index counter for the MAC term sequence; k is innermost
// and all three indices wrap to zero after the (2,2,2) term.
module ijk_counter
    import matrix_pkg::*;
(
    input  logic       clk,
    input  logic       Reset,
    input  logic       clear,
    input  logic       step,
    output logic [1:0] i,
    output logic [1:0] j,
    output logic [1:0] k,
    output logic       last_k,
    output logic       last_all
);

    localparam logic [1:0] LAST = 2'(MAT_N - 1);

    assign last_k   = (k == LAST);
    assign last_all = last_k && (j == LAST) && (i == LAST);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (Reset || clear) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (step) begin
            if (!last_k) begin
                k <= k + 2'd1;
            end else begin
                k <= '0;
                if (j != LAST) begin
                    j <= j + 2'd1;
                end else begin
                    j <= '0;
                    i <= (i == LAST) ? 2'd0 : i + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/matrix_mac_sched.sv
// 3x3 matrix product Out = A*B (mod 256) computed by sequencing 27 terms
// through one external MAC over a Load/Done handshake.
module matrix_mac_sched
    import matrix_pkg::*;
#(
    parameter int N       = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic                      Load,
    input  logic [N*N*ELEM_W-1:0]     A,
    input  logic [N*N*ELEM_W-1:0]     B,
    output logic [N*N*ELEM_W-1:0]     Out,
    output logic                      Done,
    output logic                      Err,
    output logic                      mac_load,
    output logic [ELEM_W-1:0]         mac_b,
    output logic [ELEM_W-1:0]         mac_c,
    output logic [ELEM_W-1:0]         mac_ain,
    input  logic                      mac_done,
    input  logic [ELEM_W-1:0]         mac_aout
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t                state, state_nx;
    logic [N*N*ELEM_W-1:0] a_reg, b_reg;
    logic [ELEM_W-1:0]     a_m   [MAT_N][MAT_N];
    logic [ELEM_W-1:0]     b_m   [MAT_N][MAT_N];
    logic [ELEM_W-1:0]     out_m [MAT_N][MAT_N];
    logic [ELEM_W-1:0]     acc;
    logic [ELEM_W-1:0]     hold_b, hold_c, hold_ain;
    logic [ELEM_W-1:0]     issue_b, issue_c, issue_ain;
    logic [TO_W-1:0]       tmo_cnt;
    logic                  tmo_hit;
    logic                  cnt_clear, cnt_step;
    logic [1:0]            cnt_i, cnt_j, cnt_k;
    logic                  last_k, last_all;

    ijk_counter u_ijk (
        .clk      (clk),
        .Reset    (Reset),
        .clear    (cnt_clear),
        .step     (cnt_step),
        .i        (cnt_i),
        .j        (cnt_j),
        .k        (cnt_k),
        .last_k   (last_k),
        .last_all (last_all)
    );

    always_comb begin
        for (int r = 0; r < MAT_N; r++) begin
            for (int c = 0; c < MAT_N; c++) begin
                a_m[r][c] = a_reg[elem_off(r, c) +: ELEM_W];
                b_m[r][c] = b_reg[elem_off(r, c) +: ELEM_W];
                Out[elem_off(r, c) +: ELEM_W] = out_m[r][c];
            end
        end
    end

    // The 27-way operand mux: A[i][k], B[k][j], and the running sum for k>0.
    assign issue_b   = a_m[cnt_i][cnt_k];
    assign issue_c   = b_m[cnt_k][cnt_j];
    assign issue_ain = (cnt_k == 2'd0) ? '0 : acc;

    assign mac_load = (state == ISSUE);
    assign mac_b    = mac_load ? issue_b   : hold_b;
    assign mac_c    = mac_load ? issue_c   : hold_c;
    assign mac_ain  = mac_load ? issue_ain : hold_ain;

    assign tmo_hit = (tmo_cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_nx  = state;
        cnt_clear = 1'b0;
        cnt_step  = 1'b0;
        case (state)
            IDLE: begin
                if (Load) begin
                    state_nx  = ISSUE;
                    cnt_clear = 1'b1;
                end
            end
            ISSUE: state_nx = BLANK;
            BLANK: state_nx = WAIT;
            WAIT: begin
                if (mac_done) begin
                    cnt_step = 1'b1;
                    state_nx = last_all ? IDLE : ISSUE;
                end else if (tmo_hit) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            Done     <= 1'b1;
            Err      <= 1'b0;
            tmo_cnt  <= '0;
            hold_b   <= '0;
            hold_c   <= '0;
            hold_ain <= '0;
            // NOTE: the result array is reset element by element because Out
            // must read zero after reset; it is nine flops, not a RAM.
            for (int r = 0; r < MAT_N; r++) begin
                for (int c = 0; c < MAT_N; c++) begin
                    out_m[r][c] <= '0;
                end
            end
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (Load) begin
                        a_reg <= A;
                        b_reg <= B;
                        acc   <= '0;
                        Err   <= 1'b0;
                        Done  <= 1'b0;
                    end
                end
                ISSUE: begin
                    hold_b   <= issue_b;
                    hold_c   <= issue_c;
                    hold_ain <= issue_ain;
                end
                BLANK: tmo_cnt <= '0;
                WAIT: begin
                    if (mac_done) begin
                        acc <= mac_aout;
                        if (last_k) begin
                            out_m[cnt_i][cnt_j] <= mac_aout;
                        end
                        if (last_all) begin
                            Done <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        Err  <= 1'b1;
                        Done <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/matrix_mac_sched.md
# matrix_mac_sched

Sequencer that computes the 3x3 matrix product Out = A·B (8-bit, modulo 256) by time-multiplexing a single external `mac` unit instead of nine parallel MACs. It snapshots both operand matrices on Load, issues 27 multiply-accumulate operations in row-major (i, j, k) order over a Load/Done handshake, and collects the nine results into output registers. It sits between the matrix front end and one `mac` instance, trading throughput for area.

## Interface
- `N`, default 3: matrix dimension. Only 3 is supported; exposed for readability.
- `TIMEOUT`, default 255: maximum cycles to wait for `mac_done` per operation before flagging an error.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Load`  in  1  start request; sampled only in IDLE.
- `A`  in  72  element Aij at bits [8·(3i+j) +: 8].
- `B`  in  72  element Bij at bits [8·(3i+j) +: 8].
- `Out`  out  72  element Outij at bits [8·(3i+j) +: 8]; registered.
- `Done`  out  1  high when idle and results are stable; registered.
- `Err`  out  1  sticky timeout flag; cleared on the next accepted Load or on Reset.
- `mac_load`  out  1  one-cycle issue strobe to the MAC.
- `mac_b`, `mac_c`, `mac_ain`  out  8 each  operands to the MAC. The MAC computes mac_b·mac_c + mac_ain.
- `mac_done`  in  1  MAC idle/result-valid indicator.
- `mac_aout`  in  8  MAC result.

## Operation
- States: IDLE, ISSUE, BLANK, WAIT.
- **IDLE**
  - Done=1 and mac_load=0.
  - Load=1 snapshots A and B into internal registers, clears i/j/k, acc and Err, sets Done=0, and goes to ISSUE.
  - Load is ignored in every other state. A and B may change after the Load edge without affecting the result.
- **ISSUE** (exactly one cycle)
  - mac_load=1, mac_b=Aik, mac_c=Bkj.
  - mac_ain=0 when k=0, otherwise acc.
  - Next state is BLANK.
- **BLANK** (one cycle)
  - mac_done is ignored, covering MAC Done-deassert latency.
  - Next state is WAIT, and the timeout counter is cleared.
- **WAIT**
  - On mac_done=1:
    - acc ← mac_aout.
    - If k<2: k++ and go to ISSUE.
    - Else: Outij ← mac_aout, k←0, then advance j, and i when j wraps 2→0.
    - If (i,j)=(2,2) was just written, go to IDLE; otherwise go to ISSUE.
  - Timeout counter increments each WAIT cycle. When it reaches TIMEOUT: set Err, set Done=1, go to IDLE. Out keeps any partially updated values.
- mac_b, mac_c and mac_ain hold their last values outside ISSUE. mac_load is 0 outside ISSUE.
- Arithmetic: all sums wrap modulo 256. No saturation, no carry out.
- Reset (in any state, including mid-operation): state=IDLE, Done=1, Err=0, Out=0, acc=0, i=j=k=0, mac_load=0, mac operands=0. The MAC shares `Reset` and aborts alongside.
- Load and Reset in the same cycle: Reset wins.

## Timing
- Let D be the number of cycles from the ISSUE cycle to the first cycle in which the MAC presents mac_done=1 with a valid result (D ≥ 2).
- Each term costs D+1 cycles.
- Done falls in the cycle after Load is sampled. It rises 27·(D+1)+1 cycles after the Load-sampling edge.
- Outij updates on the edge that ends its k=2 WAIT. Out22 and Done=1 become visible on the same cycle.
- Back-to-back: Load held high while Done=1 restarts immediately, with one IDLE cycle between runs.

## Structure
- Shared package `matrix_pkg`:
  - state enum {IDLE, ISSUE, BLANK, WAIT}
  - `MAT_N`=3
  - `ELEM_W`=8
  - index-to-bit-offset function for the flattened 72-bit buses (reused by the parallel matrix block).
- One sub-module `ijk_counter`: a 3-level nested 2-bit counter with `step` input and `last_k` / `last_all` outputs, cleared synchronously by `Reset` or `clear`.
- The 27-entry operand mux stays in the top level.

## Test plan
- Reset then idle: Reset high for 2 cycles → Done=1, Err=0, Out=0, mac_load=0.
- Identity × B: A=I and B with elements 1..9; MAC model with D=2 → Out=B. Done rises exactly 82 cycles after the Load edge, and exactly 27 mac_load pulses occur.
- Wrap-around: all A=16, all B=16 → every Outij = (3·256) mod 256 = 0. Then A=B=all 0xFF → every Outij = 3 (3·0xFE01 mod 256).
- Mid-run Reset and ignored Load: pulse Reset during term 13 → IDLE, Out=0, Done=1 next cycle. Then Load with new data → correct product. A Load pulsed while busy causes no restart.
- Timeout: MAC model never reasserts mac_done, TIMEOUT=8 → Err=1 and Done=1 after 8 WAIT cycles. The next Load clears Err.
- Operand snapshot: change A and B one cycle after Load → result matches the matrices sampled at the Load edge.
